// File: rtl/alu_seq_pkg.sv
// Shared opcode and state definitions for the sequential ALU.
// Pure declarations; no logic, no latency.
// Imported by the ALU top level and its combinational datapath.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle datapath for every opcode except MUL: result plus carry/overflow.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the outputs are captured.
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o,
  output logic             cf_o,
  output logic             of_o
);

  logic [SHW-1:0] sh_n;
  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] diff_w;
  logic [WIDTH:0] shl_w;
  logic [WIDTH:0] shr_w;
  logic           add_ovf;
  logic           sub_ovf;

  assign sh_n   = b_i[SHW-1:0];
  // Extra top bit of sum/diff is the carry / borrow.
  assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_w = {1'b0, a_i} - {1'b0, b_i};
  // A guard bit beside the operand catches the last bit shifted out;
  // with n=0 the guard stays 0, which is the required CF.
  assign shl_w  = {1'b0, a_i} << sh_n;
  assign shr_w  = {a_i, 1'b0} >> sh_n;

  // Signed overflow: same-sign operands flipping sign (add), or
  // different-sign operands whose result takes B's sign (sub).
  assign add_ovf = (a_i[WIDTH-1] ~^ b_i[WIDTH-1]) & (sum_w[WIDTH-1]  ^ a_i[WIDTH-1]);
  assign sub_ovf = (a_i[WIDTH-1] ^  b_i[WIDTH-1]) & (diff_w[WIDTH-1] ^ a_i[WIDTH-1]);

  // Opcode select of result and carry/overflow flags.
  always_comb begin
    res_o = '0;
    cf_o  = 1'b0;
    of_o  = 1'b0;
    unique case (op_i)
      OP_ADD: begin
        res_o = sum_w[WIDTH-1:0];
        cf_o  = sum_w[WIDTH];
        of_o  = add_ovf;
      end
      OP_SUB, OP_CMP: begin
        res_o = diff_w[WIDTH-1:0];
        cf_o  = diff_w[WIDTH];
        of_o  = sub_ovf;
      end
      OP_AND: res_o = a_i & b_i;
      OP_OR:  res_o = a_i | b_i;
      OP_SHL: begin
        res_o = shl_w[WIDTH-1:0];
        cf_o  = shl_w[WIDTH];
      end
      OP_SHR: begin
        res_o = shr_w[WIDTH:1];
        cf_o  = shr_w[0];
      end
      default: ;  // MUL is handled by the iterator in the top level
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: latches operands on start, executes, registers result and flags.
// Latency: 2 cycles start->done for single-cycle ops, WIDTH+1 cycles for MUL.
// Backpressure: start is ignored while busy; a new op may start on the done cycle.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ctl,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             ZF,
  output logic             CF,
  output logic             SF,
  output logic             OF
);

  localparam int CNTW = $clog2(WIDTH + 1);

  state_t state_q, state_d;

  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;

  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0]   out_q, out_d;
  logic               zf_q, zf_d, cf_q, cf_d, sf_q, sf_d, of_q, of_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_cf, alu_of;
  logic               accept;
  logic               mul_last;

  assign accept   = (state_q == ST_IDLE) && start;
  assign mul_last = (state_q == ST_MUL) && (cnt_q == CNTW'(WIDTH - 1));

  alu_seq_comb #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_comb (
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .res_o (alu_res),
    .cf_o  (alu_cf),
    .of_o  (alu_of)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: single EXEC cycle, or WIDTH MUL iterations with no early exit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = (ctl == OP_MUL) ? ST_MUL : ST_EXEC;
      ST_EXEC: state_d = ST_IDLE;
      ST_MUL:  if (mul_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Shift-add iterator: one multiplier bit per MUL cycle.
  always_comb begin
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (accept && (ctl == OP_MUL)) begin
      prod_d   = '0;
      mcand_d  = {{WIDTH{1'b0}}, in1};
      mplier_d = in2;
      cnt_d    = '0;
    end else if (state_q == ST_MUL) begin
      if (mplier_q[0]) prod_d = prod_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNTW'(1);
    end
  end

  // Result/flag update: only when an op retires; CMP leaves out untouched.
  always_comb begin
    out_d  = out_q;
    zf_d   = zf_q;
    cf_d   = cf_q;
    sf_d   = sf_q;
    of_d   = of_q;
    done_d = 1'b0;
    if (state_q == ST_EXEC) begin
      done_d = 1'b1;
      if (op_q != OP_CMP) out_d = alu_res;
      zf_d = (alu_res == '0);
      sf_d = alu_res[WIDTH-1];
      cf_d = alu_cf;
      of_d = alu_of;
    end else if (mul_last) begin
      // prod_d already includes the final iteration's partial product.
      done_d = 1'b1;
      out_d  = prod_d[WIDTH-1:0];
      zf_d   = (prod_d[WIDTH-1:0] == '0);
      sf_d   = prod_d[WIDTH-1];
      cf_d   = |prod_d[2*WIDTH-1:WIDTH];
      of_d   = |prod_d[2*WIDTH-1:WIDTH];
    end
  end

  // Operand capture on an accepted start; held for the whole operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= OP_ADD;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= ctl;
      a_q  <= in1;
      b_q  <= in2;
    end
  end

  // Multiply working registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Registered result, flags and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      zf_q   <= 1'b0;
      cf_q   <= 1'b0;
      sf_q   <= 1'b0;
      of_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      zf_q   <= zf_d;
      cf_q   <= cf_d;
      sf_q   <= sf_d;
      of_q   <= of_d;
      done_q <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign out  = out_q;
  assign ZF   = zf_q;
  assign CF   = cf_q;
  assign SF   = sf_q;
  assign OF   = of_q;

endmodule
